merge_sched: RTL and testbench

- Sequencing controller for the output merge stage.
- Per message: clears the output FIFO, enables the varint and raw-data producers, and pushes fields into the output FIFO in strict ascending index order.
- Each field is taken from whichever producer currently holds the matching index.
- Adds message framing (start/field count/done), abort, duplicate/order/timeout error detection, and a FIFO data-mux select.

---
 rtl/merge_sched_if.sv | 74 +++++++
 rtl/merge_sched.sv | 184 ++++++++++++++++++
 tb/tb_merge_sched.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/merge_sched_if.sv
// Handshake bundle between the merge sequencer and the FIFO and producer side.
// The master modport is the sequencer; the slave modport is its environment.
interface merge_sched_if #(
  parameter int unsigned IDX_W = 10
) ();

  logic             start;
  logic             abort;
  logic [IDX_W-1:0] field_count;
  logic             out_fifo_full;
  logic             out_fifo_clr;
  logic             out_fifo_push;
  logic             out_sel;
  logic             varint_enable;
  logic             raw_data_enable;
  logic [IDX_W-1:0] varint_out_index_q;
  logic [IDX_W-1:0] raw_data_out_index_q;
  logic             varint_data_valid;
  logic             raw_data_valid;
  logic             varint_data_accepted;
  logic             raw_data_accepted;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_code;
  logic [15:0]      stall_cycles;

  modport master (
    input  start,
    input  abort,
    input  field_count,
    input  out_fifo_full,
    input  varint_out_index_q,
    input  raw_data_out_index_q,
    input  varint_data_valid,
    input  raw_data_valid,
    output out_fifo_clr,
    output out_fifo_push,
    output out_sel,
    output varint_enable,
    output raw_data_enable,
    output varint_data_accepted,
    output raw_data_accepted,
    output busy,
    output done,
    output error,
    output err_code,
    output stall_cycles
  );

  modport slave (
    output start,
    output abort,
    output field_count,
    output out_fifo_full,
    output varint_out_index_q,
    output raw_data_out_index_q,
    output varint_data_valid,
    output raw_data_valid,
    input  out_fifo_clr,
    input  out_fifo_push,
    input  out_sel,
    input  varint_enable,
    input  raw_data_enable,
    input  varint_data_accepted,
    input  raw_data_accepted,
    input  busy,
    input  done,
    input  error,
    input  err_code,
    input  stall_cycles
  );

endinterface

// File: rtl/merge_sched.sv
// Merge-stage sequencer: frames a message and pushes fields from the varint/raw producers in
// ascending index order. Define MERGE_SCHED_PERF_EN to build the stall_cycles counter.
module merge_sched #(
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset,
  merge_sched_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMatch,
    StPush,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0]  ErrNone    = 2'd0;
  localparam logic [1:0]  ErrDup     = 2'd1;
  localparam logic [1:0]  ErrOrder   = 2'd2;
  localparam logic [1:0]  ErrTimeout = 2'd3;
  localparam logic [15:0] StallLast  = 16'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [15:0]      stall_q, stall_d;
  logic             sel_q, sel_d;
  logic             error_q, error_d;
  logic [1:0]       code_q, code_d;

  logic clr_q, push_q, en_q, vacc_q, racc_q, busy_q, done_q;
  logic vhit, rhit, vlow, rlow;

  always_comb begin
    vhit = bus.varint_data_valid && (bus.varint_out_index_q == out_index_q);
    rhit = bus.raw_data_valid && (bus.raw_data_out_index_q == out_index_q);
    vlow = bus.varint_data_valid && (bus.varint_out_index_q < out_index_q);
    rlow = bus.raw_data_valid && (bus.raw_data_out_index_q < out_index_q);
  end

  always_comb begin
    state_d     = state_q;
    out_index_d = out_index_q;
    count_d     = count_q;
    stall_d     = stall_q;
    sel_d       = sel_q;
    error_d     = error_q;
    code_d      = code_q;

    if (bus.abort) begin
      state_d     = StIdle;
      out_index_d = '0;
      stall_d     = '0;
      error_d     = 1'b0;
      code_d      = ErrNone;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (bus.start) begin
            state_d = StClear;
            count_d = bus.field_count;
            error_d = 1'b0;
            code_d  = ErrNone;
          end else if (state_q == StDone) begin
            state_d = StIdle;
          end
        end
        StClear: begin
          out_index_d = '0;
          stall_d     = '0;
          state_d     = (count_q == '0) ? StDone : StMatch;
        end
        StMatch: begin
          if (vhit || rhit) stall_d = '0;
          if (vhit && rhit) begin
            state_d = StErr;
            error_d = 1'b1;
            code_d  = ErrDup;
          end else if (vlow || rlow) begin
            state_d = StErr;
            error_d = 1'b1;
            code_d  = ErrOrder;
          end else if (bus.out_fifo_full) begin
            // Backpressure only waits; it never advances the timeout.
            state_d = StMatch;
          end else if (vhit) begin
            state_d = StPush;
            sel_d   = 1'b0;
          end else if (rhit) begin
            state_d = StPush;
            sel_d   = 1'b1;
          end else begin
            stall_d = stall_q + 16'd1;
            if (stall_q == StallLast) begin
              state_d = StErr;
              error_d = 1'b1;
              code_d  = ErrTimeout;
            end
          end
        end
        StPush: begin
          out_index_d = out_index_q + IDX_W'(1);
          state_d     = (out_index_d == count_q) ? StDone : StMatch;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are flopped from the next state so every pulse lines up with its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      out_index_q <= '0;
      count_q     <= '0;
      stall_q     <= '0;
      sel_q       <= 1'b0;
      error_q     <= 1'b0;
      code_q      <= ErrNone;
      clr_q       <= 1'b0;
      push_q      <= 1'b0;
      en_q        <= 1'b0;
      vacc_q      <= 1'b0;
      racc_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_index_q <= out_index_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
      sel_q       <= sel_d;
      error_q     <= error_d;
      code_q      <= code_d;
      clr_q       <= (state_d == StClear);
      push_q      <= (state_d == StPush);
      en_q        <= (state_d == StMatch) || (state_d == StPush);
      vacc_q      <= (state_d == StPush) && !sel_d;
      racc_q      <= (state_d == StPush) && sel_d;
      busy_q      <= state_d inside {StClear, StMatch, StPush};
      done_q      <= (state_d == StDone);
    end
  end

  assign bus.out_fifo_clr         = clr_q;
  assign bus.out_fifo_push        = push_q;
  assign bus.out_sel              = sel_q;
  assign bus.varint_enable        = en_q;
  assign bus.raw_data_enable      = en_q;
  assign bus.varint_data_accepted = vacc_q;
  assign bus.raw_data_accepted    = racc_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.error                = error_q;
  assign bus.err_code             = code_q;

`ifdef MERGE_SCHED_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (bus.abort || (state_d == StClear)) begin
      perf_d = '0;
    end else if ((state_q == StMatch) && (bus.out_fifo_full || !(vhit || rhit)) &&
                 (perf_q != 16'hffff)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign bus.stall_cycles = perf_q;
`else
  assign bus.stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_merge_sched.sv
// Randomized scoreboard bench for merge_sched: a producer model feeds indices, a monitor
// compares every clr/push/done/error event against the expected event queue.
module tb_merge_sched;

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int EvPush0 = 0, EvPush1 = 1, EvDone = 2, EvClr = 3, EvErr1 = 4;

  logic clk = 1'b0;
  logic reset;

  merge_sched_if #(.IDX_W(IDX_W)) bus ();

  merge_sched #(.IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int push_seen = 0;

  // Producer model state, owned by the main process
  int vq[$];
  int rq[$];
  int vgap, rgap;
  bit gaps_on, manual;
  int full_mode;
  logic m_vv, m_rv;
  logic [IDX_W-1:0] m_vi, m_ri;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Producers present their queue fronts while enabled; fronts are dropped on accept.
  task automatic step();
    @(negedge clk);
    if (bus.varint_data_accepted && vq.size() > 0) begin
      vq.delete(0);
      vgap = gaps_on ? int'($urandom_range(2)) : 0;
    end else if (vgap > 0) vgap--;
    if (bus.raw_data_accepted && rq.size() > 0) begin
      rq.delete(0);
      rgap = gaps_on ? int'($urandom_range(2)) : 0;
    end else if (rgap > 0) rgap--;
    if (manual) begin
      bus.varint_data_valid    = m_vv;
      bus.varint_out_index_q   = m_vi;
      bus.raw_data_valid       = m_rv;
      bus.raw_data_out_index_q = m_ri;
    end else begin
      bus.varint_data_valid    = bus.varint_enable && vq.size() > 0 && vgap == 0;
      bus.varint_out_index_q   = vq.size() > 0 ? IDX_W'(vq[0]) : '0;
      bus.raw_data_valid       = bus.raw_data_enable && rq.size() > 0 && rgap == 0;
      bus.raw_data_out_index_q = rq.size() > 0 ? IDX_W'(rq[0]) : '0;
    end
    case (full_mode)
      0:       bus.out_fifo_full = 1'b0;
      1:       bus.out_fifo_full = ($urandom_range(3) == 0);
      default: bus.out_fifo_full = 1'b1;
    endcase
  endtask

  function automatic int owner_of(input int idx);
    foreach (vq[k]) if (vq[k] == idx) return EvPush0;
    return EvPush1;
  endfunction

  task automatic expect_msg(input int n);
    exp_q.push_back(EvClr);
    for (int i = 0; i < n; i++) exp_q.push_back(owner_of(i));
    exp_q.push_back(EvDone);
  endtask

  task automatic start_msg(input int n);
    bus.start       = 1'b1;
    bus.field_count = IDX_W'(n);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < limit) begin
      step();
      k++;
    end
    step();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_pushes(input int n, input int limit);
    int np = 0;
    int k  = 0;
    while (np < n && k < limit) begin
      step();
      if (bus.out_fifo_push) np++;
      k++;
    end
    chk("push_wait", np, n);
  endtask

  task automatic wait_error(input int limit);
    int k = 0;
    while (!bus.error && k < limit) begin
      step();
      k++;
    end
    chk("error_wait", bus.error, 1);
  endtask

  // Monitor: every observable event must match the next scoreboard entry
  int   mon_cyc = 0;
  int   last_cyc = 0;
  int   ev;
  logic prev_err = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (reset) begin
        prev_err = 1'b0;
      end else begin
        ev = -1;
        if (bus.out_fifo_clr) ev = EvClr;
        else if (bus.out_fifo_push) ev = bus.out_sel ? EvPush1 : EvPush0;
        else if (bus.done) ev = EvDone;
        else if (bus.error && !prev_err) ev = EvErr1 + int'(bus.err_code) - 1;
        prev_err = bus.error;
        if (ev >= 0) begin
          if (exp_q.size() == 0) chk("unexpected_event", ev, -1);
          else chk("event_order", ev, exp_q.pop_front());
          if (ev == EvPush0 || ev == EvPush1) begin
            push_seen++;
            chk("accept_varint", bus.varint_data_accepted, !bus.out_sel);
            chk("accept_raw", bus.raw_data_accepted, bus.out_sel);
            chk("push_spacing", (mon_cyc - last_cyc) >= 2, 1);
          end
          if (ev == EvDone) chk("done_latency", mon_cyc - last_cyc, 1);
          if (ev >= EvErr1) chk("err_quiet", {bus.varint_enable, bus.raw_data_enable, bus.busy}, 0);
          if (ev == EvClr || ev == EvPush0 || ev == EvPush1) last_cyc = mon_cyc;
        end else if (bus.varint_data_accepted || bus.raw_data_accepted) begin
          chk("stray_accept", {bus.varint_data_accepted, bus.raw_data_accepted}, 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ps, en_cyc, k;
    int n;
    bit bad;
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.field_count = '0; bus.out_fifo_full = 1'b0;
    bus.varint_data_valid = 1'b0; bus.raw_data_valid = 1'b0;
    bus.varint_out_index_q = '0; bus.raw_data_out_index_q = '0;
    vgap = 0; rgap = 0; gaps_on = 0; manual = 0; full_mode = 0;
    m_vv = 0; m_rv = 0; m_vi = '0; m_ri = '0;
    repeat (3) @(negedge clk);
    chk("reset_pulses", {bus.out_fifo_clr, bus.out_fifo_push, bus.done,
                         bus.varint_data_accepted, bus.raw_data_accepted}, 0);
    chk("reset_enables", {bus.varint_enable, bus.raw_data_enable, bus.out_sel}, 0);
    chk("reset_status", {bus.busy, bus.error, bus.err_code}, 0);
    chk("reset_stall", bus.stall_cycles, 0);
    reset = 1'b0;
    step();

    // Interleaved sources, all valid immediately
    vq = '{0, 2}; rq = '{1, 3};
    expect_msg(4);
    start_msg(4);
    wait_idle("interleave_drain", 60);
    chk("interleave_stall", bus.stall_cycles, 0);

    // Sustained backpressure must not time out
    vq = '{0}; rq = '{1, 2};
    expect_msg(3);
    full_mode = 2;
    start_msg(3);
    k = 0;
    while (!bus.varint_enable && k < 10) begin step(); k++; end
    chk("enable_wait", bus.varint_enable, 1);
    ps = push_seen;
    repeat (300) step();
    bus.out_fifo_full = 1'b0;
    full_mode = 0;
    chk("full_no_push", push_seen - ps, 0);
    chk("full_no_error", bus.error, 0);
    wait_idle("full_drain", 60);
`ifdef MERGE_SCHED_PERF_EN
    chk("full_stall_cycles", bus.stall_cycles, 300);
`else
    chk("full_stall_cycles", bus.stall_cycles, 0);
`endif

    // Both sources hold index 1 at out_index 1
    vq = '{0, 1}; rq = '{1, 2};
    exp_q.push_back(EvClr); exp_q.push_back(EvPush0); exp_q.push_back(EvErr1);
    start_msg(3);
    wait_error(40);
    chk("dup_code", bus.err_code, 1);
    chk("dup_enables", {bus.varint_enable, bus.raw_data_enable}, 0);
    vq.delete(); rq.delete();
    step();
    chk("dup_drain", exp_q.size(), 0);

    // Raw index 0 shows up at out_index 2; restart clears the error
    vq = '{0, 1};
    exp_q.push_back(EvClr); exp_q.push_back(EvPush0); exp_q.push_back(EvPush0);
    exp_q.push_back(EvErr1 + 1);
    start_msg(4);
    wait_pushes(2, 40);
    manual = 1; m_vv = 0; m_rv = 1; m_ri = '0; m_vi = '0;
    bus.varint_data_valid = 1'b0; bus.raw_data_valid = 1'b1; bus.raw_data_out_index_q = '0;
    wait_error(40);
    chk("order_code", bus.err_code, 2);
    manual = 0;
    vq = '{0}; rq.delete();
    expect_msg(1);
    start_msg(1);
    chk("restart_clears_error", {bus.error, bus.err_code}, 0);
    chk("restart_clr", bus.out_fifo_clr, 1);
    wait_idle("restart_drain", 40);

    // Nothing valid: timeout on exactly the TIMEOUT-th MATCH cycle
    vq.delete(); rq.delete();
    exp_q.push_back(EvClr); exp_q.push_back(EvErr1 + 2);
    start_msg(2);
    en_cyc = 0; k = 0;
    while (!bus.error && k < 40) begin
      step();
      if (bus.varint_enable) en_cyc++;
      k++;
    end
    chk("timeout_cycles", en_cyc, TIMEOUT);
    chk("timeout_code", bus.err_code, 3);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_clears_error", {bus.error, bus.err_code}, 0);

    // Abort together with start at out_index 2
    vq = '{0, 1}; rq = '{3, 4};
    exp_q.push_back(EvClr); exp_q.push_back(EvPush0); exp_q.push_back(EvPush0);
    start_msg(5);
    wait_pushes(2, 40);
    step();
    bus.abort = 1'b1; bus.start = 1'b1;
    step();
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("abort_quiet", {bus.busy, bus.varint_enable, bus.raw_data_enable, bus.done}, 0);
    chk("abort_stall", bus.stall_cycles, 0);
    bad = 0;
    repeat (10) begin
      step();
      if (bus.busy || bus.done || bus.out_fifo_clr) bad = 1;
    end
    chk("abort_stays_idle", bad, 0);
    chk("abort_drain", exp_q.size(), 0);
    vq.delete(); rq.delete();
    exp_q.push_back(EvClr); exp_q.push_back(EvDone);
    start_msg(0);
    wait_idle("empty_msg", 20);
    vq = '{0};
    expect_msg(1);
    start_msg(1);
    wait_idle("post_abort_index", 40);

    // Start in the DONE cycle is honoured
    vq = '{0};
    exp_q.push_back(EvClr); exp_q.push_back(EvPush0); exp_q.push_back(EvDone);
    exp_q.push_back(EvClr); exp_q.push_back(EvPush0); exp_q.push_back(EvDone);
    start_msg(1);
    k = 0;
    while (!bus.done && k < 20) begin step(); k++; end
    chk("done_wait", bus.done, 1);
    vq.push_back(0);
    start_msg(1);
    wait_idle("back_to_back", 40);

    // Randomized messages with gaps, backpressure and stray starts while busy
    gaps_on = 1;
    for (int m = 0; m < 20; m++) begin
      n = (m == 0) ? 15 : int'($urandom_range(15, 1));
      vq.delete(); rq.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(1) == 0) vq.push_back(i);
        else rq.push_back(i);
      end
      expect_msg(n);
      full_mode = 1;
      start_msg(n);
      if (m % 3 == 0) begin
        bus.start = 1'b1; bus.field_count = '0;
        step();
        bus.start = 1'b0;
      end
      wait_idle("random_msg", 400);
      full_mode = 0;
    end
    gaps_on = 0;

    // Reset mid-message drops everything at once
    vq = '{0}; rq.delete();
    exp_q.push_back(EvClr); exp_q.push_back(EvPush0);
    start_msg(3);
    wait_pushes(1, 20);
    step();
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {bus.out_fifo_clr, bus.out_fifo_push, bus.varint_enable,
                             bus.raw_data_enable, bus.varint_data_accepted,
                             bus.raw_data_accepted, bus.busy, bus.done, bus.error}, 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("midreset_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
